mux4_scan_ctrl: RTL
===================

MUX4_SCAN_CTRL -- requirements
Module: mux4_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 2: cycles each channel is held selected before its sample is taken. The legal range is 1..15.
REQ-002 Parameter CONTINUOUS, default 0: when 1, a new scan starts automatically after each accepted word.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request one scan; honoured only in IDLE.
REQ-006 abort  in  1  synchronous cancel of any scan or held word.
REQ-007 data_in  in  1  mux4 Data_out, i.e. the selected channel bit.
REQ-008 sel1  out  1  mux4 select MSB, registered.
REQ-009 sel2  out  1  mux4 select LSB, registered.
REQ-010 word_out  out  4  assembled word; bit n is channel dn.
REQ-011 valid  out  1  word_out is available for transfer.
REQ-012 ready  in  1  consumer accepts word_out.
REQ-013 busy  out  1  high in SCAN or HOLD.
REQ-014 frame_cnt  out  8  count of accepted words.

Function
REQ-015 The block SHALL drive {sel1,sel2} = channel index n (0..3) to select input dn of the downstream mux4.
REQ-016 The FSM SHALL have exactly three states: IDLE, SCAN and HOLD.
REQ-017 IDLE: {sel1,sel2}=00, valid=0, busy=0; start=1 at an edge moves the FSM to SCAN with channel=0 and dwell counter=0.
REQ-018 SCAN: {sel1,sel2}=channel.
- The dwell counter increments each cycle.
- On the edge where the counter equals SETTLE-1, data_in is captured into shadow bit [channel] and the counter clears.
- If channel<3, channel increments.
REQ-019 Channel 3 capture: on the capture edge for channel 3, the block SHALL:
- load word_out from the shadow register, with the final bit included;
- set valid=1;
- enter HOLD;
- drive {sel1,sel2}=00.
REQ-020 Latency: valid SHALL rise exactly 4*SETTLE clock edges after the edge that samples start. For SETTLE=2 this is 8 edges.
REQ-021 word_out SHALL change only on entry to HOLD and on reset; it is stable during SCAN, IDLE and back-pressure.
REQ-022 HOLD: valid stays 1 until an edge with ready=1. At that edge:
- valid clears;
- frame_cnt increments;
- the FSM goes to IDLE (CONTINUOUS=0) or to SCAN with channel=0 and counter=0 (CONTINUOUS=1).
REQ-023 frame_cnt SHALL wrap from 255 to 0 with no other effect.
REQ-024 start SHALL be ignored in SCAN and HOLD; it is not queued.
REQ-025 abort=1 at any edge SHALL force IDLE, clear valid and the shadow register, and leave word_out and frame_cnt unchanged.
REQ-026 abort SHALL take priority over start, and over ready in HOLD; an abort edge SHALL NOT count as a transfer.
REQ-027 ready SHALL be ignored when valid=0.
REQ-028 SETTLE=1 SHALL capture each channel on its first selected cycle, giving valid 4 edges after start.
REQ-029 data_in SHALL be sampled only on capture edges; its value at other times SHALL have no effect.

Reset
REQ-030 When rst=1, regardless of clk, the block SHALL force:
- state=IDLE;
- {sel1,sel2}=00;
- word_out=0000;
- valid=0;
- busy=0;
- frame_cnt=0;
- shadow=0000;
- channel=0;
- dwell counter=0.
REQ-031 Reset asserted mid-scan or in HOLD SHALL discard the partial or held word; after release the block SHALL wait in IDLE for start.
REQ-032 No output SHALL toggle during the first clock edge after rst deasserts unless start=1 at that edge.

Verification
REQ-033 Basic scan: SETTLE=2, mux4 fed d0..d3=1,0,1,1, start pulse, ready=1 -> sel sequence 00,01,10,11 at 2 cycles each; valid rises 8 edges after start; word_out=4'b1101; frame_cnt=1.
REQ-034 Back-pressure: ready=0 for 10 cycles after valid while the d inputs change -> valid held high, word_out stays 4'b1101, sel=00, no rescan; ready=1 -> valid drops next edge.
REQ-035 Continuous mode: CONTINUOUS=1, ready=1, all d=1 -> back-to-back words 4'b1111; the new scan starts on the transfer edge; frame_cnt goes 1,2,3.
REQ-036 Abort: abort during channel 2 of a scan -> IDLE next edge, sel=00, valid=0, word_out keeps its previous value, frame_cnt unchanged; a start in the same cycle as abort is ignored.
REQ-037 Reset mid-operation: rst asserted between clock edges during SCAN -> outputs reach reset values immediately with no clock edge; a later start produces a correct full word.
REQ-038 Wrap: 256 accepted words -> frame_cnt returns to 0; word_out remains correct throughout.

Source files
------------

// File: rtl/mux4_scan_ctrl_if.sv
// Word transfer bundle between the scan controller and its consumer.
// The producer drives word_out/valid, the consumer answers with ready.
interface mux4_scan_ctrl_if;
  logic [3:0] word_out;
  logic       valid;
  logic       ready;

  modport master (
    output word_out,
    output valid,
    input  ready
  );

  modport slave (
    input  word_out,
    input  valid,
    output ready
  );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Steps a downstream mux4 through its four inputs.
// It samples each channel and hands the assembled word over a valid/ready link.
module mux4_scan_ctrl #(
  parameter int unsigned SETTLE     = 2,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    data_in,
  output logic                    sel1,
  output logic                    sel2,
  output logic                    busy,
  output logic [7:0]              frame_cnt,
  mux4_scan_ctrl_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [1:0] ch, ch_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] shadow, shadow_n;
  logic [3:0] word, word_n;
  logic       valid, valid_n;
  logic [7:0] frame_n;
  logic [1:0] sel, sel_n;
  logic       busy_n;

  assign bus.word_out = word;
  assign bus.valid    = valid;
  assign sel1         = sel[1];
  assign sel2         = sel[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= 2'd0;
      cnt       <= 4'd0;
      shadow    <= 4'd0;
      word      <= 4'd0;
      valid     <= 1'b0;
      frame_cnt <= 8'd0;
      sel       <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      cnt       <= cnt_n;
      shadow    <= shadow_n;
      word      <= word_n;
      valid     <= valid_n;
      frame_cnt <= frame_n;
      sel       <= sel_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    ch_n     = ch;
    cnt_n    = cnt;
    shadow_n = shadow;
    word_n   = word;
    valid_n  = valid;
    frame_n  = frame_cnt;
    if (abort) begin
      state_n  = IDLE;
      ch_n     = 2'd0;
      cnt_n    = 4'd0;
      shadow_n = 4'd0;
      valid_n  = 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            state_n = SCAN;
            ch_n    = 2'd0;
            cnt_n   = 4'd0;
          end
        end
        (state == SCAN): begin
          if (cnt == LAST) begin
            cnt_n        = 4'd0;
            shadow_n[ch] = data_in;
            if (ch == 2'd3) begin
              // final bit bypasses the shadow so the word is whole on HOLD entry
              word_n  = {data_in, shadow[2:0]};
              valid_n = 1'b1;
              state_n = HOLD;
            end else begin
              ch_n = ch + 2'd1;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        (state == HOLD): begin
          if (bus.ready) begin
            valid_n = 1'b0;
            frame_n = frame_cnt + 8'd1;
            ch_n    = 2'd0;
            cnt_n   = 4'd0;
            state_n = CONTINUOUS ? SCAN : IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // selects and busy are registered from the next state so they never glitch
    sel_n  = (state_n == SCAN) ? ch_n : 2'd0;
    busy_n = (state_n != IDLE);
  end

endmodule
